// File: rtl/dcache_write_scoreboard.sv
// D-cache write scoreboard: compares observed writes, in order, against a runtime-loaded golden table.
// Optional first-mismatch capture ports are enabled with `define SB_FIRST_ERR_LOG_EN.
//
// state | meaning
// LOAD  | golden table being filled; writes ignored
// RUN   | comparing writes, duration counting
// DONE  | all expected writes seen (terminal)
// TOUT  | TIMEOUT cycles elapsed before completion (terminal)
module dcache_write_scoreboard #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 10000,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
`ifdef SB_FIRST_ERR_LOG_EN
  output logic              first_err_vld,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
`endif
  output logic [7:0]        error_num,
  output logic [15:0]       duration,
  output logic              finish,
  output logic              timeout,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_TOUT = 2'b11
  } state_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);
  localparam logic [15:0]    TOUT_LAST = 16'(TIMEOUT - 1);

  state_t                   st;
  logic [IDX_W:0]           ld_ptr, chk_ptr, n_exp;
  logic [ADDR_W+DATA_W-1:0] table_mem [DEPTH];

  logic                     ld_take, mismatch, last_wr;
  logic [IDX_W:0]           ld_ptr_nxt, chk_ptr_inc;

  always_comb begin
    ld_take     = (st == S_LOAD) && ld_en && (ld_ptr != DEPTH_C);
    ld_ptr_nxt  = ld_take ? ld_ptr + ONE_C : ld_ptr;
    chk_ptr_inc = chk_ptr + ONE_C;
    mismatch    = {addr, data} != table_mem[chk_ptr[IDX_W-1:0]];
    last_wr     = wen && (chk_ptr_inc == n_exp);
  end

  // Table contents deliberately survive reset so a rerun can reuse them.
  always_ff @(posedge clk) begin
    if (ld_take) table_mem[ld_ptr[IDX_W-1:0]] <= {ld_addr, ld_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_LOAD;
      ld_ptr    <= '0;
      chk_ptr   <= '0;
      n_exp     <= '0;
      error_num <= '0;
      duration  <= '0;
      finish    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      unique case (st)
        S_LOAD: begin
          ld_ptr <= ld_ptr_nxt;
          if (start) begin
            n_exp <= ld_ptr_nxt;
            if (ld_ptr_nxt == '0) begin
              st     <= S_DONE;
              finish <= 1'b1;
            end else begin
              st <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (duration != 16'hFFFF) duration <= duration + 16'd1;
          if (wen) begin
            chk_ptr <= chk_ptr_inc;
            if (mismatch && error_num != 8'hFF) error_num <= error_num + 8'd1;
          end
          // Completion takes priority over a coincident timeout.
          if (last_wr) begin
            st     <= S_DONE;
            finish <= 1'b1;
          end else if (duration == TOUT_LAST) begin
            st      <= S_TOUT;
            finish  <= 1'b1;
            timeout <= 1'b1;
          end
        end
        S_DONE, S_TOUT: ;
        default: st <= S_LOAD;
      endcase
    end
  end

`ifdef SB_FIRST_ERR_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_vld  <= 1'b0;
      first_err_idx  <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (st == S_RUN && wen && mismatch && !first_err_vld) begin
      first_err_vld  <= 1'b1;
      first_err_idx  <= chk_ptr[IDX_W-1:0];
      first_err_addr <= addr;
      first_err_data <= data;
    end
  end
`endif

  assign state = st;

endmodule

// File: tb/tb_dcache_write_scoreboard.sv
// Directed bench for dcache_write_scoreboard: a small instance (DEPTH=8, TIMEOUT=20) and a
// large one (DEPTH=512) share stimulus; each scenario checks the instance it targets.
`timescale 1ns/100ps
module tb_dcache_write_scoreboard;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          wen = 1'b0;

  logic [7:0]  s_err, b_err;
  logic [15:0] s_dur, b_dur;
  logic        s_fin, b_fin, s_tout, b_tout;
  logic [1:0]  s_st, b_st;
`ifdef SB_FIRST_ERR_LOG_EN
  logic          s_fe_vld, b_fe_vld;
  logic [2:0]    s_fe_idx;
  logic [8:0]    b_fe_idx;
  logic [AW-1:0] s_fe_addr, b_fe_addr;
  logic [DW-1:0] s_fe_data, b_fe_data;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcache_write_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .TIMEOUT(20)) u_small (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .addr(addr), .data(data), .wen(wen),
`ifdef SB_FIRST_ERR_LOG_EN
    .first_err_vld(s_fe_vld), .first_err_idx(s_fe_idx),
    .first_err_addr(s_fe_addr), .first_err_data(s_fe_data),
`endif
    .error_num(s_err), .duration(s_dur), .finish(s_fin), .timeout(s_tout), .state(s_st)
  );

  dcache_write_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(512), .TIMEOUT(1000)) u_big (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .addr(addr), .data(data), .wen(wen),
`ifdef SB_FIRST_ERR_LOG_EN
    .first_err_vld(b_fe_vld), .first_err_idx(b_fe_idx),
    .first_err_addr(b_fe_addr), .first_err_data(b_fe_data),
`endif
    .error_num(b_err), .duration(b_dur), .finish(b_fin), .timeout(b_tout), .state(b_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ga(input int i);
    return AW'(32'h0010_0000 + i * 4);
  endfunction

  function automatic logic [DW-1:0] gd(input int i);
    return 32'hA5A5_0000 ^ (i * 32'h0101_0203);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_en = 1'b0; start = 1'b0; wen = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input int i);
    ld_en = 1'b1; ld_addr = ga(i); ld_data = gd(i);
    tick();
    ld_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen = 1'b1; addr = a; data = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic check_small(input string tag, input int st, input int fin, input int tout,
                             input int err, input int dur);
    check({tag, "_state"}, 32'(s_st), 32'(st));
    check({tag, "_finish"}, 32'(s_fin), 32'(fin));
    check({tag, "_timeout"}, 32'(s_tout), 32'(tout));
    check({tag, "_errnum"}, 32'(s_err), 32'(err));
    check({tag, "_dur"}, 32'(s_dur), 32'(dur));
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    check_small("rst", 0, 0, 0, 0, 0);
    check("rst_big_state", 32'(b_st), 0);
`ifdef SB_FIRST_ERR_LOG_EN
    check("rst_fe_vld", 32'(s_fe_vld), 0);
    check("rst_fe_idx", 32'(s_fe_idx), 0);
`endif

    // 1: three matching writes
    for (int i = 0; i < 3; i++) load(i);
    wr(ga(0), gd(0));                       // ignored in LOAD
    go();
    check("t1_run_state", 32'(s_st), 1);
    check("t1_run_dur", 32'(s_dur), 0);
    for (int i = 0; i < 3; i++) wr(ga(i), gd(i));
    check_small("t1", 2, 1, 0, 0, 3);
    wr(ga(0), 32'hDEAD_BEEF);
    start = 1'b1; tick(); start = 1'b0;
    check_small("t1_hold", 2, 1, 0, 0, 3);

    // 2: second write has data bit0 flipped, third has a bad address
    do_reset();
    for (int i = 0; i < 3; i++) load(i);
    go();
    wr(ga(0), gd(0));
    wr(ga(1), gd(1) ^ 32'h1);
    check("t2_mid_finish", 32'(s_fin), 0);
    wr(ga(2) ^ 30'h4, gd(2));
    check_small("t2", 2, 1, 0, 2, 3);
`ifdef SB_FIRST_ERR_LOG_EN
    check("t2_fe_vld", 32'(s_fe_vld), 1);
    check("t2_fe_idx", 32'(s_fe_idx), 1);
    check("t2_fe_addr", 32'(s_fe_addr), 32'(ga(1)));
    check("t2_fe_data", 32'(s_fe_data), 32'(gd(1) ^ 32'h1));
`endif

    // 3: timeout after a single write
    do_reset();
    load(0); load(1);
    go();
    wr(ga(0), gd(0));
    n = 0;
    while (!s_fin && n < 40) begin
      tick();
      n++;
    end
    check("t3_wait_cycles", 32'(n), 19);
    check_small("t3", 3, 1, 1, 0, 20);
    tick();
    check("t3_hold_dur", 32'(s_dur), 20);

    // 3b: completing write on the timeout cycle wins
    do_reset();
    load(0);
    go();
    repeat (19) tick();
    check("t3b_dur_pre", 32'(s_dur), 19);
    wr(ga(0), gd(0));
    check_small("t3b", 2, 1, 0, 0, 20);

    // 4: empty table
    do_reset();
    go();
    check_small("t4", 2, 1, 0, 0, 0);

    // 4b: load and start in the same cycle, load taken first
    do_reset();
    ld_en = 1'b1; ld_addr = ga(5); ld_data = gd(5); start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    check("t4b_state", 32'(s_st), 1);
    wr(ga(5), gd(5));
    check_small("t4b", 2, 1, 0, 0, 1);

    // 5a: DEPTH+2 strobes into the small instance, only 8 taken
    do_reset();
    for (int i = 0; i < 10; i++) load(i);
    go();
    for (int i = 0; i < 8; i++) wr(ga(i), gd(i));
    check_small("t5a", 2, 1, 0, 0, 8);
    check("t5a_big_running", 32'(b_st), 1);

    // 5b: 300 mismatching writes into the large instance saturate error_num
    do_reset();
    for (int i = 0; i < 300; i++) load(i);
    go();
    for (int i = 0; i < 300; i++) wr(ga(i), gd(i) ^ 32'h8000_0000);
    check("t5b_err", 32'(b_err), 255);
    check("t5b_fin", 32'(b_fin), 1);
    check("t5b_state", 32'(b_st), 2);
    check("t5b_dur", 32'(b_dur), 300);
    check("t5b_small_err", 32'(s_err), 8);

    // 6: asynchronous reset mid-run, then rerun
    do_reset();
    for (int i = 0; i < 3; i++) load(i);
    go();
    wr(ga(0), gd(0) ^ 32'h10);
    check("t6_pre_err", 32'(s_err), 1);
    #2;
    rst = 1'b1;
    #0.5;
    check_small("t6_rst", 0, 0, 0, 0, 0);
`ifdef SB_FIRST_ERR_LOG_EN
    check("t6_rst_fe_vld", 32'(s_fe_vld), 0);
`endif
    #0.5;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) load(i);
    go();
    for (int i = 0; i < 3; i++) wr(ga(i), gd(i));
    check_small("t6_rerun", 2, 1, 0, 0, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
